// File: rtl/bus_pkg.sv
// Shared types for the two-requester bus arbiter: FSM state encoding,
// the bundled requester payload and the default timeout read data.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data_write;
        logic [3:0]  write_mask;
        logic        ren;
        logic        wen;
    } bus_req_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating wait counter for a granted transfer.
// The expired flag is raised once the count reaches MAX_COUNT.
module bus_timeout_counter #(
    parameter int unsigned MAX_COUNT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != MAX_C)) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == MAX_C);

endmodule

// File: rtl/bus_arbiter_2.sv
// Two-requester round-robin arbiter onto a single bus host port, with a
// per-transfer wait timeout that completes the transfer with ERR_DATA.
module bus_arbiter_2
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = bus_pkg::ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] m0_address,
    input  logic [31:0] m0_data_write,
    input  logic [3:0]  m0_write_mask,
    input  logic        m0_ren,
    input  logic        m0_wen,
    output logic [31:0] m0_data_read,
    output logic        m0_ready,

    input  logic [31:0] m1_address,
    input  logic [31:0] m1_data_write,
    input  logic [3:0]  m1_write_mask,
    input  logic        m1_ren,
    input  logic        m1_wen,
    output logic [31:0] m1_data_read,
    output logic        m1_ready,

    output logic [31:0] bus_address,
    output logic [31:0] bus_data_write,
    output logic [3:0]  bus_write_mask,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic [31:0] bus_data_read,
    input  logic        bus_ready,
    output logic        bus_err
);

    arb_state_t  state_q, state_d;
    logic        last_served_q, last_served_d;

    bus_req_t    m0_req, m1_req, sel_req;
    logic        req0, req1;
    logic        grant_idx, own_req, other_req;
    logic        timeout, done;
    logic [31:0] rdata;
    logic        cnt_clear, cnt_enable, cnt_expired;

    assign m0_req = {m0_address, m0_data_write, m0_write_mask, m0_ren, m0_wen};
    assign m1_req = {m1_address, m1_data_write, m1_write_mask, m1_ren, m1_wen};
    assign req0   = m0_ren | m0_wen;
    assign req1   = m1_ren | m1_wen;

    always_comb begin
        state_d        = state_q;
        last_served_d  = last_served_q;
        grant_idx      = 1'b0;
        sel_req        = '0;
        own_req        = 1'b0;
        other_req      = 1'b0;
        timeout        = 1'b0;
        done           = 1'b0;
        rdata          = '0;
        bus_address    = '0;
        bus_data_write = '0;
        bus_write_mask = '0;
        bus_ren        = 1'b0;
        bus_wen        = 1'b0;
        bus_err        = 1'b0;
        m0_ready       = 1'b0;
        m0_data_read   = '0;
        m1_ready       = 1'b0;
        m1_data_read   = '0;

        unique case (state_q)
            IDLE: begin
                // Tie goes to whoever was not served last.
                if (req0 && req1) begin
                    state_d = last_served_q ? GRANT0 : GRANT1;
                end else if (req0) begin
                    state_d = GRANT0;
                end else if (req1) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                grant_idx = (state_q == GRANT1);
                sel_req   = grant_idx ? m1_req : m0_req;
                own_req   = grant_idx ? req1 : req0;
                other_req = grant_idx ? req0 : req1;
                timeout   = cnt_expired && !bus_ready && own_req;
                done      = bus_ready || timeout;
                rdata     = timeout ? ERR_DATA : bus_data_read;

                bus_address    = sel_req.address;
                bus_data_write = sel_req.data_write;
                bus_write_mask = sel_req.write_mask;
                bus_ren        = sel_req.ren && !timeout;
                bus_wen        = sel_req.wen && !timeout;
                bus_err        = timeout;

                if (grant_idx) begin
                    m1_ready     = done;
                    m1_data_read = rdata;
                end else begin
                    m0_ready     = done;
                    m0_data_read = rdata;
                end

                if (done) begin
                    last_served_d = grant_idx;
                    if (other_req) begin
                        state_d = grant_idx ? GRANT0 : GRANT1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!own_req) begin
                    // Abandoned transfer: no completion, fairness history kept.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
        end
    end

    // Any state change (including GRANT0 <-> GRANT1 handover) restarts the wait count.
    assign cnt_clear  = (state_d != state_q);
    assign cnt_enable = (state_q != IDLE) && !bus_ready;

    bus_timeout_counter #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

endmodule

// File: tb/tb_bus_arbiter_2.sv
// Directed bench for bus_arbiter_2: single read, tie, round-robin,
// abandon, timeout and mid-transfer reset with hand-computed expectations.
module tb_bus_arbiter_2;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_address, m0_data_write, m0_data_read;
    logic [3:0]  m0_write_mask;
    logic        m0_ren, m0_wen, m0_ready;
    logic [31:0] m1_address, m1_data_write, m1_data_read;
    logic [3:0]  m1_write_mask;
    logic        m1_ren, m1_wen, m1_ready;
    logic [31:0] bus_address, bus_data_write, bus_data_read;
    logic [3:0]  bus_write_mask;
    logic        bus_ren, bus_wen, bus_ready, bus_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_arbiter_2 #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0_address     (m0_address),
        .m0_data_write  (m0_data_write),
        .m0_write_mask  (m0_write_mask),
        .m0_ren         (m0_ren),
        .m0_wen         (m0_wen),
        .m0_data_read   (m0_data_read),
        .m0_ready       (m0_ready),
        .m1_address     (m1_address),
        .m1_data_write  (m1_data_write),
        .m1_write_mask  (m1_write_mask),
        .m1_ren         (m1_ren),
        .m1_wen         (m1_wen),
        .m1_data_read   (m1_data_read),
        .m1_ready       (m1_ready),
        .bus_address    (bus_address),
        .bus_data_write (bus_data_write),
        .bus_write_mask (bus_write_mask),
        .bus_ren        (bus_ren),
        .bus_wen        (bus_wen),
        .bus_data_read  (bus_data_read),
        .bus_ready      (bus_ready),
        .bus_err        (bus_err)
    );

    task automatic clear_inputs();
        m0_address = '0; m0_data_write = '0; m0_write_mask = '0; m0_ren = 1'b0; m0_wen = 1'b0;
        m1_address = '0; m1_data_write = '0; m1_write_mask = '0; m1_ren = 1'b0; m1_wen = 1'b0;
        bus_data_read = '0; bus_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        m0_ren = 1'b1; m0_address = 32'hAAAA_0000; bus_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus_ren !== 1'b0) begin failures++; $display("FAIL reset_bus_ren got=%b exp=0", bus_ren); end
        checks++; if (bus_address !== 32'h0) begin failures++; $display("FAIL reset_bus_address got=%h exp=0", bus_address); end
        checks++; if (m0_ready !== 1'b0) begin failures++; $display("FAIL reset_m0_ready got=%b exp=0", m0_ready); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_address = 32'h0000_1000; m0_ren = 1'b1;
        #1;
        checks++; if (bus_ren !== 1'b0) begin failures++; $display("FAIL rd_idle_ren got=%b exp=0", bus_ren); end
        @(negedge clk); #1;
        checks++; if ({bus_ren, bus_address} !== {1'b1, 32'h0000_1000}) begin failures++; $display("FAIL rd_strobe got=%b/%h exp=1/00001000", bus_ren, bus_address); end
        checks++; if (m0_ready !== 1'b0) begin failures++; $display("FAIL rd_wait1_ready got=%b exp=0", m0_ready); end
        @(negedge clk); #1;
        checks++; if (m0_ready !== 1'b0) begin failures++; $display("FAIL rd_wait2_ready got=%b exp=0", m0_ready); end
        @(negedge clk);
        bus_data_read = 32'h1234_5678; bus_ready = 1'b1;
        #1;
        checks++; if (m0_ready !== 1'b1) begin failures++; $display("FAIL rd_done_ready got=%b exp=1", m0_ready); end
        checks++; if (m0_data_read !== 32'h1234_5678) begin failures++; $display("FAIL rd_data got=%h exp=12345678", m0_data_read); end
        checks++; if ({m1_ready, m1_data_read} !== 33'h0) begin failures++; $display("FAIL rd_m1_quiet got=%b/%h exp=0/0", m1_ready, m1_data_read); end
        @(negedge clk);
        m0_ren = 1'b0; bus_ready = 1'b0; bus_data_read = '0;
        #1;
        checks++; if ({bus_ren, m0_ready} !== 2'b00) begin failures++; $display("FAIL rd_back_idle got=%b%b exp=00", bus_ren, m0_ready); end
    endtask

    task automatic test_tie();
        do_reset();
        m0_address = 32'h0000_0A00; m0_ren = 1'b1;
        m1_address = 32'h0000_0B00; m1_wen = 1'b1; m1_data_write = 32'hCAFE_0001;
        bus_ready = 1'b1;
        #1;
        checks++; if ({bus_ren, bus_wen} !== 2'b00) begin failures++; $display("FAIL tie_idle got=%b%b exp=00", bus_ren, bus_wen); end
        @(negedge clk); #1;
        checks++; if (bus_address !== 32'h0000_0A00) begin failures++; $display("FAIL tie_first_addr got=%h exp=00000a00", bus_address); end
        checks++; if ({m0_ready, m1_ready} !== 2'b10) begin failures++; $display("FAIL tie_first_ready got=%b%b exp=10", m0_ready, m1_ready); end
        @(negedge clk);
        m0_ren = 1'b0;
        #1;
        checks++; if ({bus_address, bus_wen} !== {32'h0000_0B00, 1'b1}) begin failures++; $display("FAIL tie_second got=%h/%b exp=00000b00/1", bus_address, bus_wen); end
        checks++; if (bus_data_write !== 32'hCAFE_0001) begin failures++; $display("FAIL tie_second_wdata got=%h exp=cafe0001", bus_data_write); end
        checks++; if ({m0_ready, m1_ready} !== 2'b01) begin failures++; $display("FAIL tie_second_ready got=%b%b exp=01", m0_ready, m1_ready); end
        @(negedge clk);
        m1_wen = 1'b0; bus_ready = 1'b0;
        #1;
        checks++; if (bus_wen !== 1'b0) begin failures++; $display("FAIL tie_end_idle got=%b exp=0", bus_wen); end
    endtask

    task automatic test_round_robin();
        logic exp0;
        do_reset();
        m0_address = 32'h0000_00C0; m0_ren = 1'b1; m0_wen = 1'b1;
        m1_address = 32'h0000_00D0; m1_ren = 1'b1;
        bus_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            exp0 = (i % 2 == 0);
            checks++; if ({m0_ready, m1_ready} !== {exp0, ~exp0}) begin failures++; $display("FAIL rr_grant%0d got=%b%b exp=%b%b", i, m0_ready, m1_ready, exp0, ~exp0); end
            if (i == 0) begin
                checks++; if ({bus_ren, bus_wen} !== 2'b11) begin failures++; $display("FAIL rr_rw_pass got=%b%b exp=11", bus_ren, bus_wen); end
            end
        end
        // Back in GRANT0: abandon without ready, last_served must stay 1.
        @(negedge clk);
        bus_ready = 1'b0; m0_ren = 1'b0; m0_wen = 1'b0; m1_ren = 1'b0;
        #1;
        checks++; if (m0_ready !== 1'b0) begin failures++; $display("FAIL abandon_ready got=%b exp=0", m0_ready); end
        @(negedge clk); #1;
        checks++; if ({bus_ren, bus_wen} !== 2'b00) begin failures++; $display("FAIL abandon_idle got=%b%b exp=00", bus_ren, bus_wen); end
        m0_ren = 1'b1; m1_ren = 1'b1; bus_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if ({m0_ready, m1_ready} !== 2'b10) begin failures++; $display("FAIL abandon_keep_rr got=%b%b exp=10", m0_ready, m1_ready); end
        @(negedge clk);
        m0_ren = 1'b0; m1_ren = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        do_reset();
        m1_address = 32'h0000_0E00; m1_wen = 1'b1; m1_data_write = 32'h5555_AAAA; m1_write_mask = 4'h5;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            checks++; if ({bus_wen, m1_ready, bus_err} !== 3'b100) begin failures++; $display("FAIL to_wait%0d got=%b%b%b exp=100", c, bus_wen, m1_ready, bus_err); end
            if (c == 1) begin
                checks++; if ({bus_write_mask, bus_data_write} !== {4'h5, 32'h5555_AAAA}) begin failures++; $display("FAIL to_payload got=%h/%h exp=5/5555aaaa", bus_write_mask, bus_data_write); end
            end
        end
        @(negedge clk); #1;
        checks++; if ({m1_ready, bus_err, bus_wen} !== 3'b110) begin failures++; $display("FAIL to_fire got=%b%b%b exp=110", m1_ready, bus_err, bus_wen); end
        checks++; if (m1_data_read !== 32'hDEAD_BEEF) begin failures++; $display("FAIL to_errdata got=%h exp=deadbeef", m1_data_read); end
        checks++; if (m0_ready !== 1'b0) begin failures++; $display("FAIL to_m0_quiet got=%b exp=0", m0_ready); end
        @(negedge clk);
        m1_wen = 1'b0;
        #1;
        checks++; if ({bus_err, bus_wen, m1_ready} !== 3'b000) begin failures++; $display("FAIL to_after got=%b%b%b exp=000", bus_err, bus_wen, m1_ready); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_address = 32'h0000_0F00; m0_ren = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus_ren !== 1'b1) begin failures++; $display("FAIL rm_granted got=%b exp=1", bus_ren); end
        @(negedge clk); #2;
        bus_ready = 1'b1; rst_n = 1'b0;
        #1;
        checks++; if ({bus_ren, bus_address} !== 33'h0) begin failures++; $display("FAIL rm_bus_zero got=%b/%h exp=0/0", bus_ren, bus_address); end
        checks++; if (m0_ready !== 1'b0) begin failures++; $display("FAIL rm_no_ready got=%b exp=0", m0_ready); end
        @(negedge clk);
        rst_n = 1'b1; m0_ren = 1'b0; bus_ready = 1'b0;
        m1_address = 32'h0000_0F10; m1_ren = 1'b1;
        #1;
        checks++; if (bus_ren !== 1'b0) begin failures++; $display("FAIL rm_idle_latency got=%b exp=0", bus_ren); end
        @(negedge clk); #1;
        checks++; if ({bus_ren, bus_address} !== {1'b1, 32'h0000_0F10}) begin failures++; $display("FAIL rm_m1_grant got=%b/%h exp=1/00000f10", bus_ren, bus_address); end
        bus_ready = 1'b1;
        #1;
        checks++; if ({m1_ready, m0_ready} !== 2'b10) begin failures++; $display("FAIL rm_m1_ready got=%b%b exp=10", m1_ready, m0_ready); end
        @(negedge clk);
        m1_ren = 1'b0; bus_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_tie();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
